hicore_skidbuf: RTL and testbench
=================================

Name: hicore_skidbuf

Overview:
- Two-entry, fully registered skid buffer for the HiCore valid/ready/cancel pipeline interface.
- It is the output-side counterpart of the bypass buffer. The bypass buffer passes valid/data combinationally and registers ready. This block registers valid/data/cancel toward the consumer and registers ready toward the producer, so there is no combinational path in either direction.
- It is inserted between pipeline stages (e.g. IFU to EXU, LSU response) to close timing while keeping 1 beat/cycle throughput.

Parameters:
- DW, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_vld  input  1  producer beat valid.
- i_rdy  output  1  buffer can accept a beat; driven directly from a register.
- i_dat  input  DW  producer payload.
- i_cancel  input  1  cancel tag carried with the beat.
- o_vld  output  1  consumer beat valid; driven directly from a register.
- o_rdy  input  1  consumer accepts the beat.
- o_dat  output  DW  consumer payload; driven directly from a register.
- o_cancel  output  1  cancel tag of the beat on o_dat.
- flush  input  1  synchronous discard of all stored beats.

Behaviour:
- Handshakes:
  - Input handshake: in_fire = i_vld & i_rdy.
  - Output handshake: out_fire = o_vld & o_rdy.
  - o_vld/o_dat/o_cancel stay stable while o_vld=1 and o_rdy=0.
  - o_vld never depends combinationally on i_vld; i_rdy never depends combinationally on o_rdy.
- Storage:
  - Main register: main_vld, main_dat, main_cancel. These drive the o_* outputs.
  - Skid register: skid_vld, skid_dat, skid_cancel.
  - i_rdy = ~skid_vld (registered).
- States, encoded by {skid_vld, main_vld}:
  - EMPTY = 00, BUSY = 01, FULL = 11.
  - 10 is illegal and must be unreachable.
- Transitions (no flush):
  - EMPTY:
    - in_fire: main <= input, go to BUSY.
    - Otherwise stay in EMPTY.
  - BUSY:
    - in_fire & out_fire: main <= input, stay in BUSY.
    - in_fire & ~out_fire: skid <= input, go to FULL.
    - ~in_fire & out_fire: go to EMPTY.
    - Otherwise hold.
  - FULL (i_rdy=0):
    - out_fire: main <= skid, skid_vld <= 0, go to BUSY.
    - Otherwise hold.
- Latency and throughput:
  - Input to output latency is exactly 1 cycle: a beat accepted in cycle N appears on o_* in cycle N+1.
  - Sustained throughput is 1 beat/cycle with o_rdy held high.
  - Order is strictly FIFO.
- Flush:
  - flush=1 at an edge forces main_vld=0 and skid_vld=0 at that edge, regardless of in_fire or out_fire.
  - A beat offered in the flush cycle is consumed if i_rdy=1, but discarded.
  - The next cycle is o_vld=0, i_rdy=1.
- Reset:
  - Values while rst=1: o_vld=0, o_cancel=0, o_dat=0, i_rdy=1, skid_vld=0, skid_dat=0, skid_cancel=0.
  - Reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.
- Data registers load only on their load enable; they do not toggle otherwise.
- Cancel is an opaque sideband bit that travels with its beat. It has no effect on flow control.

Optional Feature:
- Macro: HICORE_SKIDBUF_CANCEL_DROP_EN.
- Defined:
  - A beat with i_cancel=1 completes the input handshake (in_fire as normal), but it is not stored and the state does not change.
  - o_cancel is tied to 0.
  - The cancel registers are removed.
- Undefined:
  - Cancelled beats are stored and forwarded like any other beat, with o_cancel reflecting the stored tag.

Test Plan:
1. Streaming: o_rdy=1, i_vld=1, i_dat=1,2,3,4 on consecutive cycles -> o_dat=1,2,3,4 one cycle later, o_vld continuous, i_rdy stays 1.
2. Backpressure: fill with 0xA then 0xB while o_rdy=0 -> FULL, i_rdy=0, o_dat holds 0xA. Release o_rdy -> 0xA, then 0xB, i_rdy returns to 1 one cycle after the first out_fire.
3. Simultaneous events: in BUSY with in_fire & out_fire each cycle for 8 cycles -> state remains BUSY, no beat lost or duplicated.
4. Flush in FULL together with i_vld=1 (i_rdy=0) -> next cycle o_vld=0, i_rdy=1. No old beat ever appears on o_*.
5. Cancel: send 0x5 with i_cancel=1, then 0x6 with i_cancel=0.
   - Macro undefined -> o_cancel=1 then 0.
   - Macro defined -> only 0x6 emerges, o_cancel=0.
6. Async reset pulse mid-stream between clock edges -> o_vld=0 and i_rdy=1 immediately. Streaming resumes correctly after rst deasserts.

Source files
------------

// File: rtl/hicore_skidbuf_if.sv
// Producer/consumer handshake bundle for hicore_skidbuf: valid/ready/cancel
// on both sides plus the synchronous flush strobe.
interface hicore_skidbuf_if #(
    parameter int DW = 32
);
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          i_cancel;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic          o_cancel;
    logic          flush;

    // The buffer side.
    modport slave (
        input  i_vld, i_dat, i_cancel, o_rdy, flush,
        output i_rdy, o_vld, o_dat, o_cancel
    );

    // The surrounding pipeline side (producer and consumer).
    modport master (
        output i_vld, i_dat, i_cancel, o_rdy, flush,
        input  i_rdy, o_vld, o_dat, o_cancel
    );
endinterface

// File: rtl/hicore_skidbuf.sv
// Two-entry fully registered skid buffer: o_vld/o_dat/o_cancel and i_rdy all come straight from flops.
// Optional macro HICORE_SKIDBUF_CANCEL_DROP_EN: cancelled beats are accepted but dropped, o_cancel tied 0.
module hicore_skidbuf #(
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    hicore_skidbuf_if.slave     bus,
    output logic [1:0]          dbg_state
);
    // Valid/ready contract: a beat moves on a side exactly at an edge where
    // that side's vld and rdy are both 1; the offering side holds vld and
    // payload stable until that edge, and the buffer never lets o_vld depend
    // on i_vld nor i_rdy depend on o_rdy within a cycle.

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] main_dat;
    logic [DW-1:0] skid_dat;
    logic          in_fire;
    logic          out_fire;
    logic          in_take;
    logic          main_load;
    logic          main_from_skid;
    logic          skid_load;

    // State bits are {skid_vld, main_vld}; the outputs read them directly.
    assign bus.o_vld = state_q[0];
    assign bus.i_rdy = ~state_q[1];
    assign bus.o_dat = main_dat;
    assign dbg_state = state_q;

    assign in_fire  = bus.i_vld & bus.i_rdy;
    assign out_fire = bus.o_vld & bus.o_rdy;

`ifdef HICORE_SKIDBUF_CANCEL_DROP_EN
    assign in_take = in_fire & ~bus.i_cancel;
`else
    assign in_take = in_fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_take) state_d = BUSY;
            end
            BUSY: begin
                if (in_take && !out_fire)      state_d = FULL;
                else if (!in_take && out_fire) state_d = EMPTY;
            end
            FULL: begin
                if (out_fire) state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
    end

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: main_load = in_take;
            BUSY: begin
                main_load = in_take & out_fire;
                skid_load = in_take & ~out_fire;
            end
            FULL:    main_from_skid = out_fire;
            default: ;
        endcase
        // Flushed beats are discarded, so the data flops need not move.
        if (bus.flush) begin
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_dat <= '0;
        end else if (main_load) begin
            main_dat <= bus.i_dat;
        end else if (main_from_skid) begin
            main_dat <= skid_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_dat <= '0;
        end else if (skid_load) begin
            skid_dat <= bus.i_dat;
        end
    end

`ifdef HICORE_SKIDBUF_CANCEL_DROP_EN
    assign bus.o_cancel = 1'b0;
`else
    logic main_cancel;
    logic skid_cancel;

    assign bus.o_cancel = main_cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_cancel <= 1'b0;
        end else if (main_load) begin
            main_cancel <= bus.i_cancel;
        end else if (main_from_skid) begin
            main_cancel <= skid_cancel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_cancel <= 1'b0;
        end else if (skid_load) begin
            skid_cancel <= bus.i_cancel;
        end
    end
`endif

endmodule

// File: tb/tb_hicore_skidbuf.sv
// Bench for hicore_skidbuf: directed scenarios plus random traffic, checked by
// a monitor against a two-deep FIFO reference model held in a queue.
module tb_hicore_skidbuf;
    localparam int DW = 32;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    hicore_skidbuf_if #(.DW(DW)) bus ();

    hicore_skidbuf #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {cancel, data} of a beat the consumer is still owed.
    logic [DW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares the DUT against the model once per cycle,
    // then advances the model across the coming clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            int  n;
            logic exp_out_fire;
            logic exp_in_fire;
            n = exp_q.size();
            check("o_vld", 64'(bus.o_vld), 64'(n > 0));
            check("i_rdy", 64'(bus.i_rdy), 64'(n < 2));
            check("dbg_state", 64'(dbg_state), 64'({n == 2, n > 0}));
            if (n > 0) begin
                check("o_dat", 64'(bus.o_dat), 64'(exp_q[0][DW-1:0]));
`ifdef HICORE_SKIDBUF_CANCEL_DROP_EN
                check("o_cancel", 64'(bus.o_cancel), 64'(0));
`else
                check("o_cancel", 64'(bus.o_cancel), 64'(exp_q[0][DW]));
`endif
            end
            exp_out_fire = (n > 0) && bus.o_rdy;
            exp_in_fire  = bus.i_vld && (n < 2);
            if (exp_out_fire) void'(exp_q.pop_front());
            if (bus.flush) begin
                exp_q.delete();
            end else if (exp_in_fire) begin
`ifdef HICORE_SKIDBUF_CANCEL_DROP_EN
                if (!bus.i_cancel) exp_q.push_back({1'b0, bus.i_dat});
`else
                exp_q.push_back({bus.i_cancel, bus.i_dat});
`endif
            end
        end
    end

    // Driver: apply one cycle of inputs just after a rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic c,
                       input logic r, input logic f);
        bus.i_vld    = v;
        bus.i_dat    = d;
        bus.i_cancel = c;
        bus.o_rdy    = r;
        bus.flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_o_vld", 64'(bus.o_vld), 64'(0));
        check("rst_i_rdy", 64'(bus.i_rdy), 64'(1));
        check("rst_o_dat", 64'(bus.o_dat), 64'(0));
        check("rst_o_cancel", 64'(bus.o_cancel), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
    endtask

    // Reset pulse strictly between edges, released before the next negedge.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_vld    = 1'b0;
        bus.i_dat    = '0;
        bus.i_cancel = 1'b0;
        bus.o_rdy    = 1'b0;
        bus.flush    = 1'b0;
        #2;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming 1..4 with consumer always ready.
        for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Backpressure: fill to FULL, offer a third beat, then release.
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Simultaneous in/out fire held in BUSY.
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 32'h100 + DW'(i), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Flush while FULL with a beat offered.
        cyc(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h23, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Cancel tag travelling with its beat.
        cyc(1'b1, 32'h5, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, then resume.
        cyc(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
        bus.i_vld = 1'b1;
        bus.i_dat = 32'h32;
        pulse_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h40 + DW'(i), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 350) pulse_reset();
            cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
